// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Widest data word the parity helper accepts; narrower callers zero-extend.
  localparam int unsigned PAR_MAX_W = 16;

  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      // NOTE: non-blocking so q takes meta's pre-edge value, giving two real stages.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: start validation, mid-bit sampling, LSB-first
// shift, optional parity, valid/ready output with frame/parity/overrun pulses.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              sample_tick,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err,
  output logic              busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic              ODD       = (PARITY_ODD != 0);

  rx_state_t         state;
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bad;
  logic              rx_s;
  logic              at_full;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock  (clock),
    .resetN (resetN),
    .d      (serial_in),
    .q      (rx_s)
  );

  // One full bit period has elapsed on this tick.
  assign at_full = sample_tick && (tick_cnt == FULL_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      // NOTE: the shift register is reset too, so a frame cut by reset leaves nothing behind.
      shift_reg   <= '0;
      parity_bad  <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;

      // A load in STOP below overrides this clear in the same cycle.
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end

        START: begin
          if (sample_tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state      <= DATA;
                bit_cnt    <= '0;
                parity_bad <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end

        DATA: begin
          if (at_full) begin
            tick_cnt  <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
            bit_cnt   <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) state <= PARITY;
              else                state <= STOP;
            end
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end

        PARITY: begin
          if (at_full) begin
            tick_cnt   <= '0;
            parity_bad <= (parity_of(PAR_MAX_W'(shift_reg)) ^ rx_s) != ODD;
            state      <= STOP;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end

        STOP: begin
          if (at_full) begin
            tick_cnt <= '0;
            state    <= IDLE;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else if (parity_bad) begin
              parity_err <= 1'b1;
            end else if (data_valid && !data_ready) begin
              overrun_err <= 1'b1;
            end else begin
              data       <= shift_reg;
              data_valid <= 1'b1;
            end
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end

        BREAK: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receive deserialiser. Data width, oversampling ratio and optional parity are configurable. The block detects and validates a start bit, samples each bit at mid-bit and shifts data in LSB-first. It presents each completed word on a valid/ready handshake and reports framing, parity and overrun errors. It sits between the board serial pin and the byte-stream consumer (command parser or RX FIFO), driven by a shared baud-rate tick generator.

Parameters:
DATA_W, 8, data bits per frame (5..9)
OVERSAMPLE, 16, sample_tick pulses per bit period (even, >= 4)
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN = 0)

Ports:
clock  input  1  system clock
resetN  input  1  asynchronous active-low reset
sample_tick  input  1  one-cycle pulse, OVERSAMPLE per bit period
serial_in  input  1  asynchronous serial line, idle high
data  output  DATA_W  received word, LSB = first bit received
data_valid  output  1  data holds an unread word
data_ready  input  1  consumer accepts data when data_valid && data_ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch
overrun_err  output  1  one-cycle pulse: word completed while data_valid still high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: resetN is asynchronous and active-low; clock is clock. During reset: data = 0, data_valid = 0, all error outputs = 0, busy = 0, state = IDLE, tick counter = 0, bit counter = 0, synchroniser flops = 1.
- serial_in passes through a 2-flop synchroniser (rx_s) before any use. rx_s lags the pin by 2 clocks.
- The tick counter advances only on sample_tick. All "sample" points occur on a sample_tick.
- IDLE: when rx_s == 0, go to START and clear the tick counter.
- START: after OVERSAMPLE/2 ticks, sample rx_s.
  - rx_s == 1: glitch. Return to IDLE with no error pulse.
  - rx_s == 0: go to DATA, clear the tick counter and bit counter.
- DATA: every OVERSAMPLE ticks, shift rx_s into the MSB of the shift register (shift right). After DATA_W bits, go to PARITY if PARITY_EN, else STOP.
- PARITY: after OVERSAMPLE ticks, sample the parity bit.
  - Even parity: XOR of data bits and the parity bit must be 0. Odd parity: it must be 1.
  - Record a mismatch internally, then go to STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - rx_s == 0: pulse frame_err, discard the word, go to BREAK.
  - rx_s == 1 and parity mismatch recorded: pulse parity_err, discard the word, go to IDLE.
  - rx_s == 1 and no mismatch, data_valid == 0 or data_ready == 1 in the same cycle: load data from the shift register, set data_valid = 1, go to IDLE.
  - rx_s == 1 and no mismatch, data_valid == 1 and data_ready == 0: keep the old data, drop the new word, pulse overrun_err, go to IDLE.
- BREAK: wait for rx_s == 1, then go to IDLE. This prevents a held-low line from retriggering START.
- Handshake:
  - data_valid clears the cycle after data_valid && data_ready, unless a new word loads in that same cycle, in which case it stays 1 with the new data.
  - data is stable while data_valid is high and not accepted.
- Latency: data_valid rises 1 clock after the STOP-sample sample_tick.
- Simultaneous events: at most one error pulse per frame; priority is frame_err over parity_err over overrun_err.
- Reset mid-frame: the shift register contents are lost and the block returns to IDLE; no partial word is ever delivered.

Decomposition:
- Package uart_pkg: rx_state_t enum {IDLE, START, DATA, PARITY, STOP, BREAK}; a function returning the parity of a DATA_W vector.
- Sub-module uart_sync2: 2-flop synchroniser with parametrised reset value (1 here).
- Everything else stays in uart_rx_param.

Test Plan:
- Send 8'hA5, 8N1, OVERSAMPLE = 16, data_ready held 1 -> data = 8'hA5, data_valid high for exactly 1 clock, no error pulses.
- PARITY_EN = 1, PARITY_ODD = 0: send 8'h03 with parity 0 -> accepted. Send 8'h03 with parity 1 -> single parity_err pulse, data_valid stays 0.
- Stop bit forced low after 8'h55 -> frame_err pulse, block holds in BREAK while the line is low, then receives 8'h3C correctly after the line returns high.
- Low glitch of 4 ticks on the idle line -> returns to IDLE with no outputs asserted, busy high for 8 ticks only.
- data_ready = 0: send 8'h11 then 8'h22 -> data stays 8'h11, overrun_err pulses at the end of frame 2. Assert data_ready -> data_valid drops.
- Assert resetN = 0 at data bit 4 of 8'hFF, release, then send 8'h81 -> only 8'h81 is delivered.
